// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes two 4-bit DIP banks and accepts a new joint value only after it holds DEBOUNCE_CYCLES cycles
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s1_raw,
    input  logic [3:0] s2_raw,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic       changed,
    output logic       settling
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic {STABLE, SETTLING} state_t;
    state_t state, state_next;
    logic [7:0] sync1, sync2, candidate, stable;
    logic [CW-1:0] counter;
    logic load, accept, count;
    assign s1 = stable[3:0];
    assign s2 = stable[7:4];
    always_ff @(posedge clk) begin
        if (reset) state <= STABLE;
        else state <= state_next;
    end
    // candidate always differs from stable while settling, so sync2 == candidate implies a real change
    always_comb begin
        load = (sync2 != stable) && (state == STABLE || sync2 != candidate);
        accept = state == SETTLING && sync2 == candidate && counter == LAST;
        count = state == SETTLING && sync2 == candidate && counter != LAST;
        state_next = state == STABLE ? (sync2 != stable ? SETTLING : STABLE)
                   : (sync2 == stable || accept) ? STABLE : SETTLING;
    end
    always_comb settling = state == SETTLING;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            candidate <= '0;
            stable <= '0;
            counter <= '0;
            changed <= 1'b0;
        end else begin
            sync1 <= {s2_raw, s1_raw};
            sync2 <= sync1;
            changed <= accept;
            if (load) begin
                candidate <= sync2;
                counter <= '0;
            end else if (count) begin
                counter <= counter + CW'(1);
            end
            if (accept) stable <= candidate;
        end
    end
endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 240000, meaning consecutive clk cycles a new synchronized value must hold before acceptance (5 ms at 48 MHz); legal range 2 to 2^20.
REQ-002 SHALL have port clk  input  1  system clock (48 MHz HSOSC output).
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port s1_raw  input  4  asynchronous DIP switch bank 1, bouncy.
REQ-005 SHALL have port s2_raw  input  4  asynchronous DIP switch bank 2, bouncy.
REQ-006 SHALL have port s1  output  4  debounced bank 1 value, registered, feeds the display/summation stage.
REQ-007 SHALL have port s2  output  4  debounced bank 2 value, registered.
REQ-008 SHALL have port changed  output  1  single-cycle pulse on the cycle s1/s2 take a new value.
REQ-009 SHALL have port settling  output  1  high while a candidate value is being timed.

Function
REQ-010 SHALL treat {s2_raw, s1_raw} as one 8-bit vector raw; {s2, s1} as the 8-bit vector stable.
REQ-011 SHALL pass raw through a 2-flop synchronizer (sync1, sync2); FSM sees only sync2.
REQ-012 SHALL implement FSM states STABLE and SETTLING; settling = (state == SETTLING), combinational from state register.
REQ-013 SHALL, in STABLE, when sync2 != stable: load candidate <= sync2, counter <= 0, go SETTLING; else hold.
REQ-014 SHALL, in SETTLING, when sync2 == stable: return to STABLE, outputs unchanged, no changed pulse (glitch rejected).
REQ-015 SHALL, in SETTLING, when sync2 != stable and sync2 != candidate: candidate <= sync2, counter <= 0, stay SETTLING (restart).
REQ-016 SHALL, in SETTLING, when sync2 == candidate and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
REQ-017 SHALL, in SETTLING, when sync2 == candidate and counter == DEBOUNCE_CYCLES-1: stable <= candidate, changed <= 1 for exactly one cycle, go STABLE.
REQ-018 SHALL therefore update s1/s2 exactly DEBOUNCE_CYCLES+3 rising edges after a raw change that stays constant thereafter.
REQ-019 SHALL size counter to $clog2(DEBOUNCE_CYCLES) bits; counter never wraps (max DEBOUNCE_CYCLES-1).
REQ-020 SHALL debounce all 8 bits jointly: any bit change during SETTLING restarts timing per REQ-015.
REQ-021 SHALL hold changed low in every cycle other than those defined in REQ-017.

Reset
REQ-022 SHALL, on reset high at a rising edge, set sync1, sync2, candidate, s1, s2 to 0, counter to 0, state to STABLE, changed to 0; reset takes priority over all FSM transitions.
REQ-023 SHALL, on reset asserted mid-SETTLING, abandon the candidate; no changed pulse is produced for it.
REQ-024 SHALL, after reset release with raw != 0 held, accept raw through the normal path (changed pulses after DEBOUNCE_CYCLES+3 edges).

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-025 SHALL cover: reset, then raw 0x00 -> 0x35 held -> s1=0x5, s2=0x3 at edge 7 after change, changed high exactly that cycle, settling high edges 3-6.
REQ-026 SHALL cover: stable 0x35, raw pulses to 0x36 for 2 cycles then back -> s1/s2 stay 0x35, changed never asserts, settling returns low.
REQ-027 SHALL cover: raw 0x00 -> 0x01 for 3 cycles -> 0x03 held -> counter restarts, outputs become 0x03 at 7 edges after the 0x03 change, one changed pulse total.
REQ-028 SHALL cover: reset asserted during SETTLING toward 0xFF -> outputs 0x00, changed 0, state STABLE; raw still 0xFF after release -> 0xFF accepted 7 edges after first post-reset edge.
REQ-029 SHALL cover: raw toggles every cycle for 100 cycles -> outputs never change, changed never asserts.
REQ-030 SHALL cover: two sequential accepted changes 0x00 -> 0x11 -> 0x22, each held 10 cycles -> exactly two changed pulses, each one cycle wide.
